// File: rtl/example_mux_pkg.sv
// Shared constants and helpers for the example_mux registered 2:1 selector.
package example_mux_pkg;

  localparam logic SEL_D1 = 1'b0;
  localparam logic SEL_D2 = 1'b1;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 8;

  // Increment val, sticking at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/example_mux_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear and increment enable.
module example_mux_sat_cnt
  import example_mux_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign count_next = CNT_W'(sat_inc(32'(count_reg), CNT_W));

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/example_mux.sv
// Registered 2:1 selector with valid qualifier and saturating select-switch counter.
// Define EXAMPLE_MUX_PARITY_EN to add the registered d_out_par parity output.
module example_mux
  import example_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] d_out,
  output logic             out_valid,
  output logic             sel_q,
  output logic [CNT_W-1:0] switch_count
`ifdef EXAMPLE_MUX_PARITY_EN
  ,
  output logic             d_out_par
`endif
);

  logic [WIDTH-1:0] mux_next;
  logic [WIDTH-1:0] d_out_reg;
  logic             out_valid_reg;
  logic             sel_q_reg;
  logic             switch_inc;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mux_bit
      assign mux_next[gi] = (sel == SEL_D2) ? d2[gi] : d1[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_reg     <= '0;
      out_valid_reg <= 1'b0;
      sel_q_reg     <= SEL_D1;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        d_out_reg <= mux_next;
        sel_q_reg <= sel;
      end
    end
  end

  // sel_q_reg starts at SEL_D1, so the first beat after reset compares against it.
  assign switch_inc = in_valid && (sel != sel_q_reg);

  example_mux_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sat_cnt (
    .clk  (clk),
    .clr  (rst),
    .inc  (switch_inc),
    .count(switch_count)
  );

`ifdef EXAMPLE_MUX_PARITY_EN
  logic d_out_par_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_par_reg <= 1'b0;
    end else if (in_valid) begin
      d_out_par_reg <= ^mux_next;
    end
  end

  assign d_out_par = d_out_par_reg;
`endif

  assign d_out     = d_out_reg;
  assign out_valid = out_valid_reg;
  assign sel_q     = sel_q_reg;

endmodule

// File: tb/tb_example_mux.sv
// Self-checking bench for example_mux: scoreboard for a WIDTH=1 instance plus
// saturation/parity checks on a WIDTH=4, CNT_W=2 instance.
module tb_example_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       d1, d2, sel, in_valid;
  logic       d_out, out_valid, sel_q;
  logic [7:0] switch_count;

  logic [3:0] b_d1, b_d2;
  logic       b_sel, b_in_valid;
  logic [3:0] b_d_out;
  logic       b_out_valid, b_sel_q;
  logic [1:0] b_switch_count;
`ifdef EXAMPLE_MUX_PARITY_EN
  logic       d_out_par;
  logic       b_d_out_par;
`endif

  always #5 clk = ~clk;

  example_mux #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .sel(sel), .in_valid(in_valid),
    .d_out(d_out), .out_valid(out_valid), .sel_q(sel_q), .switch_count(switch_count)
`ifdef EXAMPLE_MUX_PARITY_EN
    , .d_out_par(d_out_par)
`endif
  );

  example_mux #(.WIDTH(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .d1(b_d1), .d2(b_d2), .sel(b_sel), .in_valid(b_in_valid),
    .d_out(b_d_out), .out_valid(b_out_valid), .sel_q(b_sel_q), .switch_count(b_switch_count)
`ifdef EXAMPLE_MUX_PARITY_EN
    , .d_out_par(b_d_out_par)
`endif
  );

  typedef struct {
    logic       d;
    logic       v;
    logic       s;
    logic [7:0] c;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state for the main instance.
  logic       m_dout, m_selq;
  logic [7:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_main(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(1), 32'(0));
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_d_out"},     32'(d_out),        32'(e.d));
    check({tag, "_out_valid"}, 32'(out_valid),    32'(e.v));
    check({tag, "_sel_q"},     32'(sel_q),        32'(e.s));
    check({tag, "_count"},     32'(switch_count), 32'(e.c));
    $display("%s: d_out=%0b out_valid=%0b sel_q=%0b switch_count=%0d", tag, d_out, out_valid, sel_q, switch_count);
  endtask

  // One accepted/idle beat on the main instance: predict, clock, compare.
  task automatic beat(input string tag, input logic s, input logic a, input logic b, input logic v);
    exp_t e;
    sel = s; d1 = a; d2 = b; in_valid = v;
    if (v) begin
      if (s != m_selq && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      m_dout = s ? b : a;
      m_selq = s;
    end
    e.d = m_dout; e.v = v; e.s = m_selq; e.c = m_cnt;
    sb_q.push_back(e);
    @(posedge clk); #1;
    compare_main(tag);
  endtask

  // Reset with live traffic on the inputs; every output must read zero.
  task automatic do_reset(input string tag, input int cycles);
    exp_t e;
    for (int i = 0; i < cycles; i++) begin
      rst = 1'b1;
      sel = 1'($urandom); d1 = 1'($urandom); d2 = 1'($urandom); in_valid = 1'b1;
      b_sel = 1'($urandom); b_d1 = 4'($urandom); b_d2 = 4'($urandom); b_in_valid = 1'b1;
      m_dout = 1'b0; m_selq = 1'b0; m_cnt = 8'd0;
      e.d = 1'b0; e.v = 1'b0; e.s = 1'b0; e.c = 8'd0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      compare_main(tag);
      check({tag, "_b_d_out"}, 32'(b_d_out), 32'(0));
      check({tag, "_b_count"}, 32'(b_switch_count), 32'(0));
`ifdef EXAMPLE_MUX_PARITY_EN
      check({tag, "_par"}, 32'(b_d_out_par), 32'(0));
`endif
    end
    rst = 1'b0;
    in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic beat_b(input string tag, input logic s, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic [1:0] exp_c);
    b_sel = s; b_d1 = a; b_d2 = b; b_in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, "_d_out"}, 32'(b_d_out), 32'(exp_d));
    check({tag, "_valid"}, 32'(b_out_valid), 32'(1));
    check({tag, "_count"}, 32'(b_switch_count), 32'(exp_c));
    $display("%s: d_out=%b switch_count=%0d", tag, b_d_out, b_switch_count);
  endtask

  initial begin
    logic [2:0] tt;
    logic [1:0] sat_exp;
    rst = 1'b1;
    sel = 1'b0; d1 = 1'b0; d2 = 1'b0; in_valid = 1'b0;
    b_sel = 1'b0; b_d1 = '0; b_d2 = '0; b_in_valid = 1'b0;
    m_dout = 1'b0; m_selq = 1'b0; m_cnt = 8'd0;
    #1;

    do_reset("reset", 2);

    // Full truth table, one combination per cycle.
    for (int i = 0; i < 8; i++) begin
      tt = 3'(i);
      beat($sformatf("tt_%0d%0d%0d", tt[2], tt[1], tt[0]), tt[2], tt[1], tt[0], 1'b1);
    end

    // Idle beat must hold d_out=1 even though d1 would select 1 and d2 0.
    beat("hold", 1'b0, 1'b1, 1'b0, 1'b0);
    check("hold_d_out_const", 32'(d_out), 32'(1));

    do_reset("reset_sw", 1);
    beat("sw0", 1'b0, 1'b0, 1'b1, 1'b1);
    beat("sw1", 1'b1, 1'b0, 1'b1, 1'b1);
    beat("sw2", 1'b1, 1'b1, 1'b0, 1'b1);
    beat("sw3", 1'b0, 1'b1, 1'b0, 1'b1);
    beat("sw4", 1'b1, 1'b0, 1'b1, 1'b1);
    check("sw_total", 32'(switch_count), 32'(3));

    // Build d_out=1, switch_count=2, then reset mid-stream.
    do_reset("reset_pre", 1);
    beat("pre0", 1'b1, 1'b0, 1'b1, 1'b1);
    beat("pre1", 1'b0, 1'b1, 1'b0, 1'b1);
    check("pre_count", 32'(switch_count), 32'(2));
    do_reset("midrst", 1);
    for (int i = 0; i < 20; i++) begin
      beat($sformatf("resume_%0d", i), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Saturation on the CNT_W=2 instance: 5 alternating changes.
    do_reset("reset_b", 1);
    sat_exp = 2'd0;
    for (int i = 0; i < 5; i++) begin
      if (sat_exp != 2'd3) sat_exp = sat_exp + 2'd1;
      beat_b($sformatf("sat_%0d", i), (i % 2 == 0), 4'h3, 4'hC, (i % 2 == 0) ? 4'hC : 4'h3, sat_exp);
    end

    beat_b("par_d1", 1'b0, 4'b1011, 4'b0000, 4'b1011, 2'd3);
`ifdef EXAMPLE_MUX_PARITY_EN
    check("par_d1_par", 32'(b_d_out_par), 32'(1));
`endif
    beat_b("par_d2", 1'b1, 4'b0000, 4'b1001, 4'b1001, 2'd3);
`ifdef EXAMPLE_MUX_PARITY_EN
    check("par_d2_par", 32'(b_d_out_par), 32'(0));
`endif
    b_in_valid = 1'b0;
    b_d1 = 4'b1111;
    @(posedge clk); #1;
    check("b_hold_d_out", 32'(b_d_out), 32'(4'b1001));
    check("b_hold_valid", 32'(b_out_valid), 32'(0));

    check("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/example_mux.md
Name: example_mux

Overview:
- Registered 2:1 data selector: forwards d1 when sel=0 and d2 when sel=1, with one-cycle registered output.
- Adds a valid qualifier and a saturating select-switch counter for status and debug.
- Used as a generic leaf steering element in datapaths; default WIDTH=1 gives the classic single-bit 2:1 mux.

Parameters:
- WIDTH, 1, data width of d1, d2 and d_out.
- CNT_W, 8, width of switch_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- d1  input  WIDTH  data input selected when sel=0
- d2  input  WIDTH  data input selected when sel=1
- sel  input  1  select: 0 -> d1, 1 -> d2
- in_valid  input  1  qualifies d1/d2/sel this cycle
- d_out  output  WIDTH  registered selected data
- out_valid  output  1  d_out holds a fresh result
- sel_q  output  1  select value captured with the current d_out
- switch_count  output  CNT_W  number of accepted sel changes, saturating

Behaviour:
- Reset (rst=1 at a clk edge): d_out=0, out_valid=0, sel_q=0, switch_count=0. Reset overrides all other activity, including mid-stream traffic.
- Latency is 1 cycle. On an edge with in_valid=1: d_out <= (sel ? d2 : d1), sel_q <= sel, out_valid <= 1.
- On an edge with in_valid=0: out_valid <= 0; d_out and sel_q hold their previous values.
- Truth table for WIDTH=1, (sel,d1,d2)->d_out:
  - sel=0: 000->0, 001->0, 010->1, 011->1
  - sel=1: 100->0, 101->1, 110->0, 111->1
- Select-change detection:
  - On an accepted beat (in_valid=1) where sel != sel_q, switch_count increments by 1.
  - The first accepted beat after reset compares against sel_q=0.
  - The counter saturates at all-ones and does not wrap.
- No back-pressure: every in_valid beat is accepted.
- X/Z on sel while in_valid=1 is a bench error; the RTL does not need to define the result.
- All outputs are driven only from flops. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro EXAMPLE_MUX_PARITY_EN.
- When defined:
  - Adds output port d_out_par (1 bit) = even parity (XOR reduction) of the selected data.
  - It is registered alongside d_out, cleared to 0 on reset, and held when in_valid=0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package example_mux_pkg:
  - Constants SEL_D1=1'b0 and SEL_D2=1'b1.
  - Default WIDTH and CNT_W localparams.
  - Function for saturating increment.
- One natural sub-module, example_mux_sat_cnt: parameterized saturating counter with sync active-high clear and an increment enable. The top instantiates it for switch_count.
- The mux and output registers stay in the top.

Test Plan:
- Reset: assert rst for 2 cycles with inputs toggling -> d_out=0, out_valid=0, sel_q=0, switch_count=0.
- Truth table: WIDTH=1, in_valid=1, apply all 8 (sel,d1,d2) combos, one per cycle -> d_out matches the table one cycle later, out_valid=1 throughout.
- Hold: in_valid=0 with d1=1, d2=0, sel=0 after d_out=1 -> out_valid=0, d_out stays 1.
- Switch count: accepted sel sequence 0,1,1,0,1 -> switch_count=3; with CNT_W=2, 5 alternating changes -> switch_count saturates at 3.
- Mid-operation reset: rst=1 during a stream with d_out=1 and switch_count=2 -> all outputs 0 at the next edge; the stream resumes with correct 1-cycle latency after rst=0.
- Parity (EXAMPLE_MUX_PARITY_EN, WIDTH=4): d1=4'b1011, sel=0 -> d_out=4'b1011, d_out_par=1; d2=4'b1001, sel=1 -> d_out_par=0.
